// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised IF/ID-style pipeline register carrying an (addr, inst) pair
//   over a valid/ready handshake. A main register drives the outputs and a
//   skid register absorbs one overflow beat. Because of this, ready_o is
//   decoded from the state register alone, so ready_i never reaches ready_o
//   combinationally. flush_i squashes everything and leaves a NOP bubble.
//
// Ports
//   Clk          in   clock, rising edge
//   Start        in   synchronous active-low reset
//   addr_i       in   [ADDR_W] upstream address
//   inst_i       in   [INST_W] upstream instruction
//   valid_i      in   upstream beat valid
//   ready_o      out  stage can accept a beat
//   flush_i      in   squash held and incoming beats
//   addr_o       out  [ADDR_W] downstream address
//   inst_o       out  [INST_W] downstream instruction
//   valid_o      out  downstream beat valid
//   ready_i      in   downstream accepts
//   stall_cnt_o  out  [16] cycles with valid_o=1 & ready_i=0 (saturating)
//   bubble_cnt_o out  [16] cycles with valid_o=0 (saturating)
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall_cnt_o/bubble_cnt_o.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST   = '0,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Start,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_next;
  logic [ADDR_W-1:0] r_skid_addr;
  logic [ADDR_W-1:0] w_skid_addr_next;
  logic [INST_W-1:0] r_skid_inst;
  logic [INST_W-1:0] w_skid_inst_next;
  logic              w_in_fire;
  logic              w_out_fire;

  // Handshake outputs come straight from the state register.
  assign valid_o = (r_state != S_EMPTY);
  assign ready_o = (r_state != S_FULL);
  assign addr_o  = r_addr;
  assign inst_o  = r_inst;

  assign w_in_fire  = valid_i & ready_o;
  assign w_out_fire = valid_o & ready_i;

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_inst_next      = r_inst;
    w_skid_addr_next = r_skid_addr;
    w_skid_inst_next = r_skid_inst;

    if (flush_i) begin
      // Squash: skid and any incoming beat are dropped, addr_o holds.
      w_state_next = S_EMPTY;
      w_inst_next  = NOP_INST;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_next = S_ONE;
            w_addr_next  = addr_i;
            w_inst_next  = inst_i;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_addr_next = addr_i;
            w_inst_next = inst_i;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new beat, keep main stable.
            w_state_next     = S_FULL;
            w_skid_addr_next = addr_i;
            w_skid_inst_next = inst_i;
          end else if (w_out_fire) begin
            w_state_next = S_EMPTY;
            w_inst_next  = NOP_INST;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_next = S_ONE;
            w_addr_next  = r_skid_addr;
            w_inst_next  = r_skid_inst;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
          w_inst_next  = NOP_INST;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Start) begin
      r_state <= S_EMPTY;
      r_addr  <= RESET_ADDR;
      r_inst  <= NOP_INST;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_inst  <= w_inst_next;
    end
  end

  // Skid contents are only meaningful in FULL, so they need no reset.
  always_ff @(posedge Clk) begin
    r_skid_addr <= w_skid_addr_next;
    r_skid_inst <= w_skid_inst_next;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge Clk) begin
    if (!Start) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (valid_o && !ready_i && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (!valid_o && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
